// File: rtl/str_ofs_frm_pkg.sv
// Shared definitions for the byte-offset stream blocks (framer, offset converter).
//  - log2(): bits needed to hold a value (min 1); log2(NB-1) gives the lane-index width.
//  - frm_state_t: framer FSM states.
//  - DFLT_NB / DFLT_OFS_W: lane count and offset width for the default 32/8 geometry.
package str_ofs_frm_pkg;

  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) <= n) r = i + 1;
    return r;
  endfunction

  function automatic int nb_of(input int dw, input int bw);
    return dw / bw;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } frm_state_t;

  localparam int DFLT_NB    = nb_of(32, 8);
  localparam int DFLT_OFS_W = log2(DFLT_NB - 1);

endpackage

// File: rtl/str_ofs_frm_if.sv
// AXI-stream style beat bus.
//  tdata  DW   beat data, lane 0 in the low byte
//  tkeep  NB   per-lane byte valid
//  tlast  1    last beat of frame
//  tvld   1    beat valid (source)
//  trdy   1    beat ready (sink)
// master drives the beat, slave returns trdy.
interface str_ofs_frm_if #(
  parameter int DW = 32,
  parameter int NB = 4
) ();
  logic [DW-1:0] tdata;
  logic [NB-1:0] tkeep;
  logic          tlast;
  logic          tvld;
  logic          trdy;

  modport master (output tdata, tkeep, tlast, tvld, input trdy);
  modport slave  (input tdata, tkeep, tlast, tvld, output trdy);
endinterface

// File: rtl/str_ofs_frm_merge.sv
// Combinational lane merge for offset streams.
//  hold, cur  in   previous / current input beat
//  ofs        in   lane shift: output lane i < ofs takes hold byte NB-ofs+i,
//                  lane i >= ofs takes cur byte i-ofs
//  lo, hi     in   keep window: lane i kept iff lo <= i < hi
//  data       out  merged beat, non-kept lanes forced to 0
//  keep       out  per-lane keep mask
module str_ofs_frm_merge import str_ofs_frm_pkg::*; #(
  parameter int NB    = 4,
  parameter int BW    = 8,
  parameter int OFS_W = log2(NB - 1)
) (
  input  logic [NB*BW-1:0] hold,
  input  logic [NB*BW-1:0] cur,
  input  logic [OFS_W-1:0] ofs,
  input  logic [OFS_W-1:0] lo,
  input  logic [OFS_W:0]   hi,
  output logic [NB*BW-1:0] data,
  output logic [NB-1:0]    keep
);
  logic [NB*BW-1:0] sh;

  // {cur, hold} shifted right by NB-ofs bytes lines up hold's top ofs bytes
  // with lanes [ofs-1:0] and cur's low bytes with lanes [NB-1:ofs].
  assign sh = (NB*BW)'({cur, hold} >> (BW * (NB - int'(ofs))));

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign keep[i] = ((OFS_W+1)'(i) >= {1'b0, lo}) && ((OFS_W+1)'(i) < hi);
    assign data[i*BW +: BW] = keep[i] ? sh[i*BW +: BW] : '0;
  end
endmodule

// File: rtl/str_ofs_frm.sv
// Stream framer: turns a packed headerless byte stream plus a per-frame
// command (start lane, byte length) into an offset AXI-stream frame with
// exact tkeep and tlast.
//  i_clk, i_rst      clock, synchronous active-high reset
//  i_frm_vld/o_frm_rdy, i_frm_ofs, i_frm_b_len   frame command (accepted in IDLE)
//  s_axis (slave)    packed input beats; tkeep/tlast ignored
//  m_axis (master)   framed output, one register stage
//  o_busy            frame in progress or output beat pending
module str_ofs_frm import str_ofs_frm_pkg::*; #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BYTE_WIDTH = 8,
  parameter  int LEN_W      = 32,
  localparam int NB         = DATA_WIDTH / BYTE_WIDTH,
  localparam int OFS_W      = log2(NB - 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frm_vld,
  output logic             o_frm_rdy,
  input  logic [OFS_W-1:0] i_frm_ofs,
  input  logic [LEN_W-1:0] i_frm_b_len,
  str_ofs_frm_if.slave     s_axis,
  str_ofs_frm_if.master    m_axis,
  output logic             o_busy
);
  localparam logic [LEN_W:0] NB_L = (LEN_W+1)'(NB);

  frm_state_t state, state_nxt;

  logic [OFS_W-1:0]      ofs_q;
  logic [LEN_W:0]        in_left;   // input bytes still to consume
  logic [LEN_W:0]        out_left;  // output byte positions (incl. offset) still to emit
  logic                  first_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [NB-1:0]         m_keep_q;
  logic                  m_last_q, m_vld_q;

  logic                  out_free, cmd_acc, cmd_run, in_acc, flush_go, ld_out, last_in;
  logic [OFS_W-1:0]      lo;
  logic [OFS_W:0]        hi;
  logic [DATA_WIDTH-1:0] mg_data;
  logic [NB-1:0]         mg_keep;
  logic                  unused_in;

  assign unused_in = ^{s_axis.tkeep, s_axis.tlast};

  assign out_free = ~m_vld_q | m_axis.trdy;
  assign cmd_acc  = i_frm_vld & o_frm_rdy;
  assign cmd_run  = cmd_acc & (i_frm_b_len != '0);
  assign in_acc   = s_axis.tvld & s_axis.trdy;
  assign flush_go = (state == FLUSH) & out_free;
  assign ld_out   = in_acc | flush_go;
  assign last_in  = in_left <= NB_L;

  // Keep window of the beat being built: first beat starts at ofs, and the
  // end is clipped by the remaining position count.
  assign lo = first_q ? ofs_q : '0;
  assign hi = (out_left >= NB_L) ? (OFS_W+1)'(NB) : out_left[OFS_W:0];

  str_ofs_frm_merge #(.NB(NB), .BW(BYTE_WIDTH), .OFS_W(OFS_W)) u_merge (
    .hold (hold_q),
    .cur  (s_axis.tdata),
    .ofs  (ofs_q),
    .lo   (lo),
    .hi   (hi),
    .data (mg_data),
    .keep (mg_keep)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_run) state_nxt = RUN;
      // Leftover hold bytes past the last input beat need a FLUSH beat.
      RUN:     if (in_acc && last_in) state_nxt = (out_left <= NB_L) ? IDLE : FLUSH;
      FLUSH:   if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_frm_rdy   = (state == IDLE);
    s_axis.trdy = (state == RUN) & out_free;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ofs_q    <= '0;
      in_left  <= '0;
      out_left <= '0;
      first_q  <= 1'b0;
      hold_q   <= '0;
      m_data_q <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
      m_vld_q  <= 1'b0;
    end else begin
      if (cmd_run) begin
        ofs_q    <= i_frm_ofs;
        in_left  <= {1'b0, i_frm_b_len};
        out_left <= {1'b0, i_frm_b_len} + (LEN_W+1)'(i_frm_ofs);
        first_q  <= 1'b1;
      end
      if (in_acc) begin
        hold_q  <= s_axis.tdata;
        in_left <= in_left - NB_L;
        first_q <= 1'b0;
      end
      if (ld_out) begin
        out_left <= out_left - NB_L;
        m_data_q <= mg_data;
        m_keep_q <= mg_keep;
        m_last_q <= out_left <= NB_L;
        m_vld_q  <= 1'b1;
      end else if (m_axis.trdy) begin
        m_vld_q <= 1'b0;
      end
    end
  end

  assign m_axis.tdata = m_data_q;
  assign m_axis.tkeep = m_keep_q;
  assign m_axis.tlast = m_last_q;
  assign m_axis.tvld  = m_vld_q;
  assign o_busy       = (state != IDLE) | m_vld_q;
endmodule

// File: tb/tb_str_ofs_frm.sv
// Bench for str_ofs_frm (NB=4). Frame vectors in a table, expected beats from
// a positional model pushed to a scoreboard at command time, popped on each
// output handshake; hand sequences for len=0 and mid-frame reset.
module tb_str_ofs_frm;
  import str_ofs_frm_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } sb_t;

  typedef struct {
    int         ofs;
    int         len;
    bit         rnd;
    int         beats;
    logic [3:0] keep0;
    logic [3:0] keepn;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_frm_vld;
  logic        o_frm_rdy;
  logic [1:0]  i_frm_ofs;
  logic [31:0] i_frm_b_len;
  logic        o_busy;

  str_ofs_frm_if #(.DW(32), .NB(4)) s_if ();
  str_ofs_frm_if #(.DW(32), .NB(4)) m_if ();

  str_ofs_frm #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .LEN_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_frm_vld   (i_frm_vld),
    .o_frm_rdy   (o_frm_rdy),
    .i_frm_ofs   (i_frm_ofs),
    .i_frm_b_len (i_frm_b_len),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int   checks = 0;
  int   failures = 0;
  sb_t  sb[$];
  bit   rnd_rdy = 1'b0;
  int   obs_beats, obs_tlast;
  logic [3:0] obs_keep0, obs_keepn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, 64'({o_frm_rdy, s_if.trdy, m_if.tvld, m_if.tlast, o_busy, m_if.tkeep, m_if.tdata}),
        64'({1'b1, 4'b0, 4'b0, 32'b0}));
  endtask

  task automatic obs_clear();
    obs_beats = 0; obs_tlast = 0; obs_keep0 = 'x; obs_keepn = 'x;
  endtask

  // Output sink: trdy changes just after the active edge.
  initial begin
    m_if.trdy = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      m_if.trdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: handshake and stall stability sampled on the falling edge.
  initial begin
    sb_t e, prev;
    bit  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst && prev_stall)
        chk("stall_stable", 64'({m_if.tvld, m_if.tdata, m_if.tkeep, m_if.tlast}), 64'({1'b1, prev}));
      if (!i_rst && m_if.tvld && m_if.trdy) begin
        obs_beats++;
        if (obs_beats == 1) obs_keep0 = m_if.tkeep;
        obs_keepn = m_if.tkeep;
        if (m_if.tlast) obs_tlast++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=%0h expected=none", {m_if.tdata, m_if.tkeep, m_if.tlast});
        end else begin
          e = sb.pop_front();
          chk("beat", 64'({m_if.tdata, m_if.tkeep, m_if.tlast}), 64'(e));
        end
      end
      prev_stall = !i_rst && m_if.tvld && !m_if.trdy;
      prev = {m_if.tdata, m_if.tkeep, m_if.tlast};
    end
  end

  // Called just after a rising edge. abort_after>0 stops after that many input beats.
  task automatic run_frame(input int ofs, input int len, input int abort_after, input bit rnd);
    int nin, nout, beat, cyc, stop, p;
    bit acc, vld;
    sb_t e;
    nin = (len + 3) / 4;
    nout = (ofs + len + 3) / 4;
    for (int k = 0; k < nout; k++) begin
      e = '0;
      for (int i = 0; i < 4; i++) begin
        p = k * 4 + i;
        if (p >= ofs && p < ofs + len) begin
          e.keep[i] = 1'b1;
          e.data[i*8 +: 8] = 8'(p - ofs);
        end
      end
      e.last = (k == nout - 1);
      sb.push_back(e);
    end
    i_frm_vld = 1'b1; i_frm_ofs = 2'(ofs); i_frm_b_len = 32'(len);
    cyc = 0;
    do begin
      @(negedge i_clk); acc = o_frm_rdy;
      @(posedge i_clk); #1; cyc++;
    end while (!acc && cyc < 200);
    i_frm_vld = 1'b0;
    if (!acc) begin checks++; failures++; $display("FAIL cmd_timeout actual=0 expected=1"); end
    stop = (abort_after > 0) ? abort_after : nin;
    beat = 0; vld = 1'b0; cyc = 0;
    while (beat < stop && cyc < 5000) begin
      if (!vld) vld = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.tvld = vld;
      for (int i = 0; i < 4; i++) s_if.tdata[i*8 +: 8] = 8'(beat * 4 + i);
      @(negedge i_clk); acc = vld && s_if.trdy;
      @(posedge i_clk); #1; cyc++;
      if (acc) begin beat++; vld = 1'b0; end
    end
    s_if.tvld = 1'b0;
    if (beat < stop) begin checks++; failures++; $display("FAIL in_timeout actual=%0d expected=%0d", beat, stop); end
    if (abort_after == 0) begin
      cyc = 0;
      while ((sb.size() != 0 || m_if.tvld) && cyc < 2000) begin @(posedge i_clk); #1; cyc++; end
      chk("drain_left", 64'(sb.size()), 64'd0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 10,  1'b0, 3,  4'b1111, 4'b0011};
    vecs[1] = '{3, 2,   1'b0, 2,  4'b1000, 4'b0001};
    vecs[2] = '{2, 10,  1'b0, 3,  4'b1100, 4'b1111};
    vecs[3] = '{0, 4,   1'b0, 1,  4'b1111, 4'b1111};
    vecs[4] = '{3, 1,   1'b0, 1,  4'b1000, 4'b1000};
    vecs[5] = '{1, 3,   1'b0, 1,  4'b1110, 4'b1110};
    vecs[6] = '{2, 7,   1'b0, 3,  4'b1100, 4'b0001};
    vecs[7] = '{1, 200, 1'b1, 51, 4'b1110, 4'b0001};

    i_rst = 1'b1; i_frm_vld = 1'b0; i_frm_ofs = '0; i_frm_b_len = '0;
    s_if.tvld = 1'b0; s_if.tdata = '0; s_if.tkeep = '1; s_if.tlast = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_reset("reset_state");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      rnd_rdy = vecs[v].rnd;
      obs_clear();
      run_frame(vecs[v].ofs, vecs[v].len, 0, vecs[v].rnd);
      chk($sformatf("v%0d_beats", v), 64'(obs_beats), 64'(vecs[v].beats));
      chk($sformatf("v%0d_keep0", v), 64'(obs_keep0), 64'(vecs[v].keep0));
      chk($sformatf("v%0d_keepn", v), 64'(obs_keepn), 64'(vecs[v].keepn));
      chk($sformatf("v%0d_tlasts", v), 64'(obs_tlast), 64'd1);
    end
    rnd_rdy = 1'b0;

    // len=0: accepted, no beats, ready again next cycle
    i_frm_vld = 1'b1; i_frm_ofs = 2'd2; i_frm_b_len = '0;
    @(negedge i_clk);
    chk("len0_accept", 64'(o_frm_rdy), 64'd1);
    @(posedge i_clk); #1;
    i_frm_vld = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      chk("len0_idle", 64'({o_frm_rdy, s_if.trdy, m_if.tvld, o_busy}), 64'(4'b1000));
    end
    @(posedge i_clk); #1;

    // reset mid-frame after 10 input beats, then a short frame
    obs_clear();
    run_frame(2, 200, 10, 1'b0);
    @(negedge i_clk);
    @(posedge i_clk); #1;
    chk("abort_beats", 64'(obs_beats), 64'd10);
    i_rst = 1'b1;
    sb.delete();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_reset("mid_reset");
    @(posedge i_clk); #1;
    obs_clear();
    run_frame(0, 4, 0, 1'b0);
    chk("post_rst_beats", 64'(obs_beats), 64'd1);
    chk("post_rst_keep", 64'(obs_keepn), 64'(4'b1111));
    chk("post_rst_tlast", 64'(obs_tlast), 64'd1);

    repeat (3) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
